// File: rtl/lsu_access_pkg.sv
// lsu_access_pkg: shared widths, memory opcode encodings, size-class decode and FSM states for the LSU
package lsu_access_pkg;
    localparam int XLEN          = 64;
    localparam int BUS_BYTES     = XLEN / 8;
    localparam int REG_ADDRWIDTH = 5;
    localparam int MEMOP_LEN     = 4;

    typedef enum logic [MEMOP_LEN-1:0] {
        MEMOP_NONE, MEMOP_LB, MEMOP_LH, MEMOP_LW, MEMOP_LD, MEMOP_LBU,
        MEMOP_LHU, MEMOP_LWU, MEMOP_SB, MEMOP_SH, MEMOP_SW, MEMOP_SD
    } memop_e;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

    typedef enum logic [1:0] {IDLE, REQ, RSP, OUT} state_e;

    function automatic size_e op_size(input logic [MEMOP_LEN-1:0] op);
        case (op)
            MEMOP_LB, MEMOP_LBU, MEMOP_SB: return SZ_B;
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: return SZ_H;
            MEMOP_LW, MEMOP_LWU, MEMOP_SW: return SZ_W;
            default:                       return SZ_D;
        endcase
    endfunction

    function automatic logic is_store(input logic [MEMOP_LEN-1:0] op);
        return op inside {MEMOP_SB, MEMOP_SH, MEMOP_SW, MEMOP_SD};
    endfunction

    function automatic logic is_load(input logic [MEMOP_LEN-1:0] op);
        return op inside {MEMOP_LB, MEMOP_LH, MEMOP_LW, MEMOP_LD, MEMOP_LBU, MEMOP_LHU, MEMOP_LWU};
    endfunction

    function automatic logic is_mem(input logic [MEMOP_LEN-1:0] op);
        return is_load(op) || is_store(op);
    endfunction

    function automatic logic is_signed_load(input logic [MEMOP_LEN-1:0] op);
        return op inside {MEMOP_LB, MEMOP_LH, MEMOP_LW};
    endfunction

    // Natural-alignment violation for a memory op at the given byte lane
    function automatic logic misaligned(input logic [MEMOP_LEN-1:0] op, input logic [2:0] off);
        size_e sz = op_size(op);
        return is_mem(op) && ((sz == SZ_H && off[0]) || (sz == SZ_W && off[1:0] != 2'b00) ||
                              (sz == SZ_D && off != 3'b000));
    endfunction
endpackage

// File: rtl/lsu_access_align.sv
// lsu_align: store lane shift/byte enables and load shift/extend for one 64-bit bus beat
module lsu_align
    import lsu_access_pkg::*;
(
    input  logic [MEMOP_LEN-1:0] i_op,
    input  logic [2:0]           i_off,
    input  logic [XLEN-1:0]      i_rs2,
    input  logic [63:0]          i_rdata,
    output logic [BUS_BYTES-1:0] o_wmask,
    output logic [63:0]          o_wdata,
    output logic [XLEN-1:0]      o_ldata
);
    size_e                w_size;
    logic [2:0]           w_off;
    logic [BUS_BYTES-1:0] w_smask;
    logic [63:0]          w_sh;
    logic                 w_sx;

    // Offset is aligned down to the access size so an access never straddles lanes
    always_comb begin
        w_size  = op_size(i_op);
        w_off   = i_off & (3'b111 << w_size);
        w_smask = (w_size == SZ_B) ? 8'h01 : (w_size == SZ_H) ? 8'h03 : (w_size == SZ_W) ? 8'h0F : 8'hFF;
        o_wmask = w_smask << w_off;
        o_wdata = i_rs2 << {w_off, 3'b000};
        w_sh    = i_rdata >> {w_off, 3'b000};
        w_sx    = is_signed_load(i_op);
        o_ldata = (w_size == SZ_B) ? {{(XLEN-8){w_sx & w_sh[7]}}, w_sh[7:0]} :
                  (w_size == SZ_H) ? {{(XLEN-16){w_sx & w_sh[15]}}, w_sh[15:0]} :
                  (w_size == SZ_W) ? {{(XLEN-32){w_sx & w_sh[31]}}, w_sh[31:0]} : w_sh;
    end
endmodule

// File: rtl/lsu_access.sv
// lsu_access: execute-result consumer that runs one data-memory transaction per load/store
// Optional LSU_MISALIGN_CHECK_EN: misaligned accesses skip the bus and report the faulting address
module lsu_access
    import lsu_access_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ex_valid_i,
    output logic                     ex_ready_o,
    input  logic [XLEN-1:0]          exc_alu_out_i,
    input  logic [XLEN-1:0]          rs2_data_i,
    input  logic [MEMOP_LEN-1:0]     mem_op_i,
    input  logic [REG_ADDRWIDTH-1:0] rd_idx_i,
    output logic                     dmem_req_valid_o,
    input  logic                     dmem_req_ready_i,
    output logic [XLEN-1:0]          dmem_addr_o,
    output logic                     dmem_we_o,
    output logic [63:0]              dmem_wdata_o,
    output logic [7:0]               dmem_wmask_o,
    input  logic                     dmem_rsp_valid_i,
    input  logic [63:0]              dmem_rdata_i,
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output logic [REG_ADDRWIDTH-1:0] wb_rd_idx_o,
    output logic [XLEN-1:0]          wb_data_o,
    output logic                     wb_misalign_o
);
    state_e                   r_state;
    logic [XLEN-1:0]          r_addr;
    logic [XLEN-1:0]          r_rs2;
    logic [MEMOP_LEN-1:0]     r_op;
    logic [REG_ADDRWIDTH-1:0] r_rd;
    logic [XLEN-1:0]          r_wb_data;
    logic [REG_ADDRWIDTH-1:0] r_wb_rd;
    logic                     r_misalign;
    logic [7:0]               w_wmask;
    logic [63:0]              w_wdata;
    logic [XLEN-1:0]          w_ldata;
    logic                     w_misalign;
    logic                     w_req;

    lsu_align u_align (
        .i_op    (r_op),
        .i_off   (r_addr[2:0]),
        .i_rs2   (r_rs2),
        .i_rdata (dmem_rdata_i),
        .o_wmask (w_wmask),
        .o_wdata (w_wdata),
        .o_ldata (w_ldata)
    );

`ifdef LSU_MISALIGN_CHECK_EN
    assign w_misalign = misaligned(mem_op_i, exc_alu_out_i[2:0]);
`else
    assign w_misalign = 1'b0;
`endif

    // Bus fields are only driven while a request is outstanding, so they read 0 otherwise
    assign w_req            = r_state == REQ;
    assign ex_ready_o       = r_state == IDLE;
    assign dmem_req_valid_o = w_req;
    assign dmem_addr_o      = w_req ? {r_addr[XLEN-1:3], 3'b000} : '0;
    assign dmem_we_o        = w_req & is_store(r_op);
    assign dmem_wdata_o     = w_req ? w_wdata : '0;
    assign dmem_wmask_o     = w_req ? w_wmask : '0;
    assign wb_valid_o       = r_state == OUT;
    assign wb_rd_idx_o      = r_wb_rd;
    assign wb_data_o        = r_wb_data;
    assign wb_misalign_o    = r_misalign;

    // Accept, run the optional bus request/response, then hold the writeback until it is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_rs2      <= '0;
            r_op       <= MEMOP_NONE;
            r_rd       <= '0;
            r_wb_data  <= '0;
            r_wb_rd    <= '0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (ex_valid_i) begin
                    r_addr     <= exc_alu_out_i;
                    r_rs2      <= rs2_data_i;
                    r_op       <= mem_op_i;
                    r_rd       <= rd_idx_i;
                    r_wb_data  <= exc_alu_out_i;
                    r_wb_rd    <= is_mem(mem_op_i) ? '0 : rd_idx_i;
                    r_misalign <= w_misalign;
                    r_state    <= (!is_mem(mem_op_i) || w_misalign) ? OUT : REQ;
                end
                REQ: if (dmem_req_ready_i) r_state <= RSP;
                RSP: if (dmem_rsp_valid_i) begin
                    r_wb_data <= is_store(r_op) ? '0 : w_ldata;
                    r_wb_rd   <= is_store(r_op) ? '0 : r_rd;
                    r_state   <= OUT;
                end
                OUT: if (wb_ready_i) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
